// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and widths for the register-file write arbiter
package wb_pkg;

  localparam int WB_REGISTERS = 32;
  localparam int WB_WIDTH     = 32;
  localparam int WB_AW        = $clog2(WB_REGISTERS);

  // One queued register-file write: destination index plus result data.
  typedef struct packed {
    logic [WB_AW-1:0]    rd;
    logic [WB_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO of pending port B writes with per-entry visibility
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  wb_entry_t                  i_entry,
  input  logic                       i_pop,
  output wb_entry_t                  o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic [DEPTH-1:0]           o_valid,
  output logic [DEPTH*WB_AW-1:0]     o_rd_flat
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t         r_mem [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];

  // A full FIFO refuses pushes even when it is popped the same cycle.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents need no reset because validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_entry;
  end

  // Slot g is live when its distance from the read pointer is below the occupancy.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [PW-1:0] w_off;
    assign w_off                        = PW'(g) - r_rptr;
    assign o_valid[g]                   = ({1'b0, w_off} < r_count);
    assign o_rd_flat[g*WB_AW +: WB_AW]  = r_mem[g].rd;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - merges execute and long-latency results onto the register-file write port
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int REGISTERS = WB_REGISTERS,
  parameter int WIDTH     = WB_WIDTH,
  parameter int DEPTH     = 4,
  localparam int AW       = $clog2(REGISTERS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       a_valid,
  input  logic [AW-1:0]              a_rd,
  input  logic [WIDTH-1:0]           a_data,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [AW-1:0]              b_rd,
  input  logic [WIDTH-1:0]           b_data,
  output logic                       we3,
  output logic [AW-1:0]              a3,
  output logic [WIDTH-1:0]           wd3,
  output logic [REGISTERS-1:0]       pend,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       conflict
);

  logic                 w_a_wr;
  logic                 w_b_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  wb_entry_t            w_b_entry;
  wb_entry_t            w_head;
  logic [DEPTH-1:0]     w_fifo_valid;
  logic [DEPTH*AW-1:0]  w_fifo_rd;
  logic [REGISTERS-1:0] w_pend;

  logic                 r_we3;
  logic                 r_out_b;
  logic [AW-1:0]        r_a3;
  logic [WIDTH-1:0]     r_wd3;
  logic                 r_conflict;

  // Writes to x0 are dropped on both ports; port A always wins the write port.
  assign w_a_wr    = a_valid && (a_rd != '0);
  assign b_ready   = !w_full && !reset;
  assign w_b_push  = b_valid && b_ready && (b_rd != '0);
  assign w_pop     = !w_a_wr && !w_empty;
  assign w_b_entry = '{rd: b_rd, data: b_data};

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_b_push),
    .i_entry   (w_b_entry),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (count),
    .o_valid   (w_fifo_valid),
    .o_rd_flat (w_fifo_rd)
  );

  // Pending mask: every queued B destination plus a B write sitting in the output stage.
  always_comb begin
    w_pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_fifo_valid[i]) w_pend[w_fifo_rd[i*AW +: AW]] = 1'b1;
    end
    if (r_we3 && r_out_b) w_pend[r_a3] = 1'b1;
    w_pend[0] = 1'b0;
  end

  // Output stage: register the selected write; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we3   <= 1'b0;
      r_out_b <= 1'b0;
      r_a3    <= '0;
      r_wd3   <= '0;
    end else begin
      r_we3   <= w_a_wr || w_pop;
      r_out_b <= w_pop;
      if (w_a_wr) begin
        r_a3  <= a_rd;
        r_wd3 <= a_data;
      end else if (w_pop) begin
        r_a3  <= w_head.rd;
        r_wd3 <= w_head.data;
      end
    end
  end

  // Sticky flag for an A write that overtakes an outstanding B write to the same register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_conflict <= 1'b0;
    end else if (w_a_wr && w_pend[a_rd]) begin
      r_conflict <= 1'b1;
    end
  end

  assign we3      = r_we3;
  assign a3       = r_a3;
  assign wd3      = r_wd3;
  assign pend     = w_pend;
  assign conflict = r_conflict;

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - self-checking bench for writeback_arbiter
module tb_writeback_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0;
  logic [4:0]  a_rd = '0;
  logic [31:0] a_data = '0;
  logic        b_valid = 1'b0;
  logic [4:0]  b_rd = '0;
  logic [31:0] b_data = '0;
  logic        b_ready;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [31:0] pend;
  logic [2:0]  count;
  logic        conflict;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  writeback_arbiter #(.REGISTERS(32), .WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .we3(we3), .a3(a3), .wd3(wd3), .pend(pend), .count(count), .conflict(conflict)
  );

  always #5 clk = ~clk;

  // Reference model: queue of pending {rd,data} plus the visible write-port state.
  logic [36:0] m_q[$];
  logic        m_we3 = 1'b0;
  logic        m_outb = 1'b0;
  logic [4:0]  m_a3 = '0;
  logic [31:0] m_wd3 = '0;
  logic        m_conflict = 1'b0;

  function automatic logic [31:0] model_pend();
    logic [31:0] p = '0;
    foreach (m_q[i]) p[m_q[i][36:32]] = 1'b1;
    if (m_we3 && m_outb) p[m_a3] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_we3 = 0; m_outb = 0; m_a3 = 0; m_wd3 = 0; m_conflict = 0;
    end else begin
      bit a_wr;
      bit was_full;
      logic [31:0] p;
      logic [36:0] e;
      a_wr     = a_valid && (a_rd != 0);
      was_full = (m_q.size() == DEPTH);
      p        = model_pend();
      if (a_wr && p[a_rd]) m_conflict = 1;
      if (a_wr) begin
        m_we3 = 1; m_outb = 0; m_a3 = a_rd; m_wd3 = a_data;
      end else if (m_q.size() > 0) begin
        e = m_q.pop_front();
        m_we3 = 1; m_outb = 1; m_a3 = e[36:32]; m_wd3 = e[31:0];
      end else begin
        m_we3 = 0; m_outb = 0;
      end
      if (b_valid && !was_full && b_rd != 0) m_q.push_back({b_rd, b_data});
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: DUT outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_we3", 64'(we3), 64'(m_we3));
      check("m_a3", 64'(a3), 64'(m_a3));
      check("m_wd3", 64'(wd3), 64'(m_wd3));
      check("m_pend", 64'(pend), 64'(model_pend()));
      check("m_count", 64'(count), 64'(m_q.size()));
      check("m_b_ready", 64'(b_ready), 64'((m_q.size() < DEPTH) && !reset));
      check("m_conflict", 64'(conflict), 64'(m_conflict));
    end
  end

  task automatic step(input logic rst, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic bv, input logic [4:0] brd, input logic [31:0] bd);
    @(negedge clk);
    #1;
    reset = rst; a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset state
    step(1, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    step(1, 0, 0, 0, 1, 3, 32'h55);
    check("rst_we3", 64'(we3), 0);
    check("rst_count", 64'(count), 0);
    check("rst_pend", 64'(pend), 0);
    check("rst_b_ready", 64'(b_ready), 0);
    idle(1);
    check("post_rst_b_ready", 64'(b_ready), 1);

    // Port A single write and x0 suppression
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    check("a_we3", 64'(we3), 1);
    check("a_a3", 64'(a3), 5);
    check("a_wd3", 64'(wd3), 64'hDEADBEEF);
    step(0, 1, 0, 32'h1111, 0, 0, 0);
    check("a_x0_we3", 64'(we3), 0);
    check("a_x0_wd3_hold", 64'(wd3), 64'hDEADBEEF);

    // Port B best-case latency and pend window
    step(0, 0, 0, 0, 1, 7, 32'h1234);
    check("b_pend7_n1", 64'(pend[7]), 1);
    check("b_we3_n1", 64'(we3), 0);
    idle(1);
    check("b_we3_n2", 64'(we3), 1);
    check("b_a3_n2", 64'(a3), 7);
    check("b_wd3_n2", 64'(wd3), 64'h1234);
    check("b_pend7_n2", 64'(pend[7]), 1);
    idle(1);
    check("b_pend7_n3", 64'(pend[7]), 0);

    // Starvation: A writes every cycle while B fills the FIFO
    for (int k = 1; k <= 4; k++) step(0, 1, 10, 32'(k), 1, 5'(k), 32'h100 + 32'(k));
    check("starve_count", 64'(count), 4);
    check("starve_b_ready", 64'(b_ready), 0);
    step(0, 1, 10, 32'h77, 1, 5, 32'h999);
    check("full_no_push", 64'(count), 4);
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      check("drain_a3", 64'(a3), 64'(k));
      check("drain_wd3", 64'(wd3), 64'h100 + 64'(k));
    end
    check("drain_b_ready", 64'(b_ready), 1);
    check("drain_count", 64'(count), 0);

    // Two queued writes to r9 keep pend set until the later one leaves
    step(0, 0, 0, 0, 1, 9, 32'hA);
    step(0, 0, 0, 0, 1, 9, 32'hB);
    check("r9_first_wd3", 64'(wd3), 64'hA);
    check("r9_pend_mid", 64'(pend[9]), 1);
    idle(1);
    check("r9_second_wd3", 64'(wd3), 64'hB);
    check("r9_pend_out", 64'(pend[9]), 1);
    idle(1);
    check("r9_pend_clear", 64'(pend[9]), 0);
    step(0, 1, 20, 32'h5, 1, 0, 32'hBAD);
    check("b_x0_count", 64'(count), 0);
    idle(1);
    check("b_x0_no_write", 64'(we3), 0);

    // Conflict: A overtakes a queued B write to the same register
    step(0, 0, 0, 0, 1, 9, 32'hC);
    step(0, 1, 9, 32'h99, 0, 0, 0);
    check("conf_flag", 64'(conflict), 1);
    check("conf_a3", 64'(a3), 9);
    check("conf_wd3", 64'(wd3), 64'h99);
    idle(1);
    check("conf_sticky", 64'(conflict), 1);
    check("conf_b_drained", 64'(wd3), 64'hC);

    // Reset with three entries queued
    for (int k = 0; k < 3; k++) step(0, 1, 11, 32'(k), 1, 5'(12 + k), 32'(k));
    check("pre_rst_count", 64'(count), 3);
    step(1, 0, 0, 0, 0, 0, 0);
    check("mid_rst_count", 64'(count), 0);
    check("mid_rst_pend", 64'(pend), 0);
    check("mid_rst_we3", 64'(we3), 0);
    check("mid_rst_conflict", 64'(conflict), 0);
    for (int k = 0; k < 3; k++) begin
      idle(1);
      check("post_rst_no_stale", 64'(we3), 0);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 99) < 55), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom);
    end
    idle(8);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
